// File: rtl/i2c_pkg.sv
// Shared types and line-level tables for the byte-level I2C initiator.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBit,
        StStop,
        StHold
    } state_e;

    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    // Bit n holds the line level during phase n; START ph0 SCL is overridden on repeated START.
    localparam logic [3:0] StartSclLvl = 4'b0111;
    localparam logic [3:0] StartSdaLvl = 4'b0011;
    localparam logic [3:0] StopSclLvl  = 4'b1110;
    localparam logic [3:0] StopSdaLvl  = 4'b1100;

    typedef struct packed {
        logic       stop;
        logic       read;
        logic       nack;
        logic [7:0] wdata;
    } cmd_t;

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period timer: tick on the last cycle of each phase, held at zero while stalled.
module i2c_qtick #(
    parameter int unsigned QDIV = 250
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic stall_i,
    output logic tick_o
);

    localparam int unsigned CntW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(QDIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !stall_i && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || stall_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_initiator.sv
// Byte-level I2C initiator: optional START, 8 data bits + ACK, optional STOP per command.
// Define I2C_CLK_STRETCH_EN to let a target stretch SCL in BIT ph2 and STOP ph1.
module i2c_initiator
    import i2c_pkg::*;
#(
    parameter int unsigned QDIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_start_i,
    input  logic       cmd_stop_i,
    input  logic       cmd_read_i,
    input  logic       cmd_nack_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_ack_n_o,
    output logic       busy_o,
    input  logic       scl_in_i,
    input  logic       sda_in_i,
    output logic       scl_out_o,
    output logic       sda_out_o
);

    state_e     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [3:0] bit_q, bit_d;
    cmd_t       cmd_q, cmd_d;
    logic       rep_q, rep_d;
    logic       busy_q, busy_d;
    logic [8:0] shift_q, shift_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_n_q, ack_n_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       sda_last_q;
    logic       tick, stall, accept, bit_sda, timer_en;

    assign cmd_ready_o = (state_q == StIdle) || (state_q == StHold);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign timer_en    = (state_q == StStart) || (state_q == StBit) || (state_q == StStop);

`ifdef I2C_CLK_STRETCH_EN
    assign stall = !scl_in_i && (((state_q == StBit) && (phase_q == PH2)) ||
                                 ((state_q == StStop) && (phase_q == PH1)));
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in_i;
    assign stall         = 1'b0;
`endif

    i2c_qtick #(
        .QDIV(QDIV)
    ) u_qtick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (timer_en),
        .stall_i(stall),
        .tick_o (tick)
    );

    // Slot 8 is the ACK slot; the initiator drives it only on reads.
    always_comb begin
        if (bit_q == 4'd8) begin
            bit_sda = cmd_q.read ? cmd_q.nack : 1'b1;
        end else begin
            bit_sda = cmd_q.read ? 1'b1 : cmd_q.wdata[3'd7 - bit_q[2:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        cmd_d       = cmd_q;
        rep_d       = rep_q;
        busy_d      = busy_q;
        shift_d     = shift_q;
        rdata_d     = rdata_q;
        ack_n_d     = ack_n_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            StIdle, StHold: begin
                if (accept) begin
                    cmd_d   = '{stop: cmd_stop_i, read: cmd_read_i, nack: cmd_nack_i,
                                wdata: cmd_wdata_i};
                    phase_d = PH0;
                    bit_d   = 4'd0;
                    rep_d   = (state_q == StHold);
                    if (cmd_start_i || (state_q == StIdle)) begin
                        state_d = StStart;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = StBit;
                    end
                end
            end
            StStart: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == PH3) state_d = StBit;
                end
            end
            StBit: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == PH2) shift_d = {shift_q[7:0], sda_in_i};
                    if (phase_q == PH3) begin
                        if (bit_q == 4'd8) begin
                            rsp_valid_d = 1'b1;
                            rdata_d     = shift_q[8:1];
                            ack_n_d     = cmd_q.read ? cmd_q.nack : shift_q[0];
                            state_d     = cmd_q.stop ? StStop : StHold;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == PH3) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        scl_out_o = 1'b1;
        sda_out_o = 1'b1;
        case (state_q)
            StStart: begin
                scl_out_o = (phase_q == PH0) ? !rep_q : StartSclLvl[phase_q];
                sda_out_o = StartSdaLvl[phase_q];
            end
            StBit: begin
                scl_out_o = phase_q[1];
                sda_out_o = bit_sda;
            end
            StStop: begin
                scl_out_o = StopSclLvl[phase_q];
                sda_out_o = StopSdaLvl[phase_q];
            end
            StHold: begin
                scl_out_o = 1'b0;
                sda_out_o = sda_last_q;
            end
            default: begin
                scl_out_o = 1'b1;
                sda_out_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            phase_q     <= PH0;
            bit_q       <= 4'd0;
            cmd_q       <= '0;
            rep_q       <= 1'b0;
            busy_q      <= 1'b0;
            shift_q     <= '0;
            rdata_q     <= '0;
            ack_n_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            sda_last_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            cmd_q       <= cmd_d;
            rep_q       <= rep_d;
            busy_q      <= busy_d;
            shift_q     <= shift_d;
            rdata_q     <= rdata_d;
            ack_n_q     <= ack_n_d;
            rsp_valid_q <= rsp_valid_d;
            if (state_q != StHold) sda_last_q <= sda_out_o;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_ack_n_o = ack_n_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/i2c_initiator.md
# i2c_initiator

Byte-level I2C initiator (controller) that generates the SCL/SDA line levels feeding the `scl_in`/`sda_in` side of the I2C extender. It accepts one byte command at a time over a valid/ready handshake and executes an optional START, 8 data bits plus ACK, and an optional STOP. It returns read data and ACK status as a one-cycle response pulse.

## Interface
- `QDIV`, 250: clk cycles per SCL quarter-period; ≥2 (250 @ 100 MHz = 100 kHz)
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_start`  in  1  issue (repeated) START before the byte
- `cmd_stop`  in  1  issue STOP after the byte
- `cmd_read`  in  1  1 = read byte, 0 = write `cmd_wdata`
- `cmd_nack`  in  1  read only: level driven in the ACK slot (1 = NACK)
- `cmd_wdata`  in  8  write byte, MSB first
- `rsp_valid`  out  1  one-cycle pulse per completed byte
- `rsp_rdata`  out  8  read byte (write: bits sampled from bus)
- `rsp_ack_n`  out  1  sampled ACK slot (1 = NACK)
- `busy`  out  1  bus owned (START issued, no STOP yet)
- `scl_in`, `sda_in`  in  1  sampled line levels
- `scl_out`, `sda_out`  out  1  line levels (1 = release, 0 = pull low)

## Operation
- States: IDLE, START, BIT, STOP, HOLD. `cmd_ready` = 1 in IDLE or HOLD only.
- On accept: START if `cmd_start` or if in IDLE. From IDLE, `cmd_start` = 0 is treated as 1. Then BIT ×9 (8 data + ACK). Then STOP if `cmd_stop`, else HOLD.
- Each state steps through phases ph0..ph3, each QDIV clk cycles long.
- START:
  - ph0: scl = 1 from IDLE, 0 from HOLD; sda = 1
  - ph1: scl = 1, sda = 1
  - ph2: scl = 1, sda = 0
  - ph3: scl = 0, sda = 0
- BIT:
  - ph0/ph1: scl = 0. sda is updated at the first cycle of ph0.
  - ph2/ph3: scl = 1
  - `sda_in` is sampled on the last cycle of ph2.
- Write: data slots drive `cmd_wdata[7-i]`; ACK slot releases sda and its sample becomes `rsp_ack_n`.
- Read: data slots release sda and samples shift into `rsp_rdata`; ACK slot drives `cmd_nack`; `rsp_ack_n` = `cmd_nack`.
- STOP:
  - ph0: scl = 0, sda = 0
  - ph1: scl = 1, sda = 0
  - ph2/ph3: scl = 1, sda = 1
  - then IDLE; `busy` clears on entry to IDLE.
- HOLD: scl = 0, sda holds its last level. The next command starts immediately.

## Timing
- Reset values: `scl_out` = 1, `sda_out` = 1, `cmd_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_ack_n` = 0, `busy` = 0. State IDLE, counters 0.
- Reset mid-transfer releases both lines on the next edge; a partial byte is abandoned.
- First phase starts the cycle after accept. Byte duration = (4·S + 36 + 4·P)·QDIV cycles, where S/P = START/STOP issued.
- `rsp_valid` pulses on the cycle after ph3 of the ACK slot, before any STOP.
- `cmd_ready` falls on the accept cycle and rises on IDLE/HOLD entry. Back-to-back accept is possible on that same cycle.
- `busy` sets on the first cycle of START ph0.

## Configuration
- `I2C_CLK_STRETCH_EN`:
  - Defined: in BIT ph2 and STOP ph1, the quarter counter holds at 0 while `scl_in` = 0 (target clock stretching). Sampling is delayed accordingly.
  - Undefined: `scl_in` is ignored and timing is strictly QDIV-based.

## Structure
- Package `i2c_pkg`: state enum, phase constants (PH0..PH3), per-phase SCL/SDA level constants for START/STOP.
- Sub-module `i2c_qtick`: quarter-period counter with `stall` input; emits a `tick` on the last cycle of each phase.

## Test plan
All scenarios use QDIV = 4 with an open-drain bus model (wired-AND with a target model).
- Write 0xA5 with start+stop, target ACKs:
  - 0xA5 appears MSB first on SCL rising edges
  - `rsp_valid` pulse with `rsp_ack_n` = 0 at cycle (4+36)·4+1 after accept
  - bus idle at 176 cycles
- Read with start+stop, target drives 0x3C, `cmd_nack` = 1: `rsp_rdata` = 0x3C, `rsp_ack_n` = 1, sda released in the ACK slot.
- Write 0x50 (no stop), then read with start+stop (repeated START):
  - HOLD between the two bytes
  - START ph0 keeps scl = 0
  - `busy` stays 1 throughout
- Write with no target (bus pulled high): `rsp_ack_n` = 1, `rsp_rdata` = 0xFF echo.
- Assert `rst` at bit 4 of a write: next cycle `scl_out` = `sda_out` = 1, `cmd_ready` = 1, no `rsp_valid`.
- `I2C_CLK_STRETCH_EN` defined, target holds SCL low 20 cycles at bit 2: byte completes 20 cycles later with correct data.
